led_frame_scheduler: RTL and testbench
======================================

LED_FRAME_SCHEDULER -- requirements
Module: led_frame_scheduler

Interface
REQ-001 Parameter NSTRAND, default 4: number of LED strands sharing the serializer.
REQ-002 Parameter DIV, default 256: sck half-period in clk cycles, minimum 1.
REQ-003 Ports SHALL be:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  NSTRAND  per-strand frame request, level.
- len  in  NSTRAND*5  per-strand LED count; strand i uses bits [5i+4:5i]; range 0..31.
- brightness  in  5  global brightness, sampled at grant.
- pix_rdy  out  1  scheduler ready to accept next pixel.
- pix_valid  in  1  pixel on pix_data valid.
- pix_data  in  24  {blue,green,red}, 8 bits each.
- grant  out  NSTRAND  one-hot owner of the serializer; 0 when idle.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.
- sck  out  1  shared SPI clock to all strands.
- mosi  out  NSTRAND  per-strand data; only the granted bit toggles.

Function
REQ-004 Each frame SHALL be 32 zero bits, then len LED words {3'b111,brightness,blue,green,red}, then 32 one bits, MSB first.
REQ-005 FSM states SHALL be IDLE, START, FETCH, LED, END.
REQ-006 IDLE with any req high -> next cycle: grant one-hot set, busy=1, len and brightness latched, state START.
REQ-007 Arbitration SHALL be round-robin: after serving strand k, priority order is k+1, k+2, ... wrapping at NSTRAND; after reset, strand 0 has highest priority.
REQ-008 Dropping req mid-frame SHALL NOT abort the frame; req is sampled only in IDLE.
REQ-009 sck SHALL idle low; mosi changes only while sck is low; each bit occupies DIV cycles low then DIV cycles high; the first bit is driven in the grant cycle.
REQ-010 START shifts 32 bits -> FETCH if latched len>0, else END.
REQ-011 FETCH: pix_rdy=1 and sck held low; pixel accepted on a cycle with pix_valid&&pix_rdy; the next cycle enters LED with the word loaded; unbounded stall permitted.
REQ-012 LED shifts 32 bits; LED-word counter increments; -> FETCH if counter<len, else END.
REQ-013 pix_rdy SHALL be 0 outside FETCH; pix_valid outside FETCH is ignored.
REQ-014 END shifts 32 bits; at the end of the last bit's high phase: done=1 for one cycle, grant=0, busy=0, sck low, state IDLE.
REQ-015 A new grant SHALL occur no earlier than the cycle after done.
REQ-016 Non-granted mosi bits SHALL be 0 at all times; the granted mosi bit SHALL be 0 in IDLE.
REQ-017 Frame length SHALL be (len+2)*32 bits; clk cycles excluding fetch stalls = (len+2)*64*DIV.
REQ-018 The LED-word counter SHALL be 6 bits wide so that len=31 does not wrap.

Reset
REQ-019 Asserting reset, including mid-frame, SHALL immediately force: state IDLE; sck=0; mosi=0; grant=0; busy=0; done=0; pix_rdy=0; round-robin pointer to strand 0; all counters cleared.
REQ-020 After reset deasserts, the first arbitration SHALL occur on the first clk edge with req nonzero.

Verification
REQ-021 DIV=1, req=4'b0001, len0=1, brightness=5'h18, pix 0x427AF4 offered at first pix_rdy -> mosi[0] stream 32x0, 0xF8427AF4, 32x1; done 193+ cycles after grant; grant=0 after done.
REQ-022 DIV=1, req=4'b0101 held, len=0 for all strands -> grant 0001, done, then 0100, then 0001; each frame is 64 bits; mosi[1], mosi[2] and mosi[3] stay 0 during strand 0's frame.
REQ-023 DIV=2, len0=2, pix_valid withheld 50 cycles at second FETCH -> sck held low and mosi stable for the stall, pix_rdy=1 throughout, and the frame resumes with no lost or extra bit.
REQ-024 req=4'b0010 is pulsed for 1 cycle in IDLE, then dropped -> the full frame for strand 1 completes and a single done is observed.
REQ-025 Reset asserted mid-LED word -> sck, mosi, grant and busy are 0 in the same cycle; with req=4'b1000 after release, strand 3 is granted on the next edge and restarts with 32 zeros.
REQ-026 len0=31, DIV=1 -> exactly 31 pix accepts, total 33*32 bits shifted, and done asserts once.

Source files
------------

// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler
//
// Time-shares one SPI-style LED serializer between NSTRAND strands. A strand
// raises its req level; the round-robin arbiter picks one owner, latches its
// LED count and the global brightness, and shifts one complete frame out on
// that strand's mosi bit. The frame is 32 zero bits, then one 32-bit word
// {3'b111, brightness, blue, green, red} per LED, then 32 one bits, MSB first.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   req         per-strand frame request (level, sampled only while idle)
//   len         per-strand LED count, strand i in bits [5i+4:5i]
//   brightness  global 5-bit brightness, latched at grant
//   pix_rdy     scheduler waiting for the next pixel
//   pix_valid   pixel on pix_data is valid
//   pix_data    {blue, green, red}
//   grant       one-hot owner of the serializer, 0 when idle
//   busy        a frame is in progress
//   done        one-cycle pulse when the frame's last bit completes
//   sck         shared serial clock, idles low
//   mosi        per-strand serial data, only the granted bit can be 1
//
// Pixel handshake: a pixel is transferred on every rising clk edge where
// pix_valid && pix_rdy are both high. pix_rdy is high only while the FSM is in
// FETCH, and it stays high until the transfer happens, so the source may stall
// for any number of cycles; pix_valid outside FETCH has no effect.
//
// Bit timing: each bit holds mosi for DIV cycles with sck low, then DIV cycles
// with sck high. The shift register moves on the high->low transition of sck,
// so mosi only ever changes while sck is low.

module led_frame_scheduler #(
    parameter int NSTRAND = 4,
    parameter int DIV     = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NSTRAND-1:0]     req,
    input  logic [NSTRAND*5-1:0]   len,
    input  logic [4:0]             brightness,
    output logic                   pix_rdy,
    input  logic                   pix_valid,
    input  logic [23:0]            pix_data,
    output logic [NSTRAND-1:0]     grant,
    output logic                   busy,
    output logic                   done,
    output logic                   sck,
    output logic [NSTRAND-1:0]     mosi
);

    localparam int IW = (NSTRAND > 1) ? $clog2(NSTRAND) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NSTRAND - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        FETCH = 3'd2,
        LED   = 3'd3,
        END   = 3'd4
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;     // highest-priority strand for the next arbitration
    logic [DW-1:0] div_cnt;    // cycles spent in the current sck phase
    logic [4:0]    bit_cnt;    // bit index within the current 32-bit word
    logic [5:0]    word_cnt;   // LED words sent; 6 bits so len=31 cannot wrap
    logic [4:0]    len_q;
    logic [4:0]    bright_q;
    logic [31:0]   shreg;      // shreg[31] is the bit currently on the wire

    // Round-robin arbitration: scan from rr_ptr upward, wrapping at NSTRAND.
    logic               arb_found;
    logic [IW-1:0]      arb_idx;
    logic [NSTRAND-1:0] arb_onehot;
    logic [4:0]         arb_len;

    always_comb begin
        logic [IW-1:0] idx;
        arb_found  = 1'b0;
        arb_idx    = '0;
        arb_onehot = '0;
        arb_len    = '0;
        idx        = rr_ptr;
        for (int off = 0; off < NSTRAND; off++) begin
            if (!arb_found && req[idx]) begin
                arb_found = 1'b1;
                arb_idx   = idx;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        for (int i = 0; i < NSTRAND; i++) begin
            if (arb_found && (IW'(i) == arb_idx)) begin
                arb_onehot[i] = 1'b1;
                arb_len       = len[5*i +: 5];
            end
        end
    end

    logic        phase_end;
    logic        last_bit;
    logic [5:0]  word_cnt_nxt;
    logic [31:0] led_word;

    assign phase_end    = (div_cnt == DIV_LAST);
    assign last_bit     = (bit_cnt == 5'd31);
    assign word_cnt_nxt = word_cnt + 6'd1;
    assign led_word     = {3'b111, bright_q, pix_data};

    // grant and shreg are both registers and shreg is cleared whenever the
    // serializer goes idle, so mosi is a clean AND of two flops.
    assign mosi = grant & {NSTRAND{shreg[31]}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            len_q    <= '0;
            bright_q <= '0;
            shreg    <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sck      <= 1'b0;
            pix_rdy  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        state    <= START;
                        grant    <= arb_onehot;
                        busy     <= 1'b1;
                        len_q    <= arb_len;
                        bright_q <= brightness;
                        rr_ptr   <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
                        shreg    <= '0;       // first start bit is on the wire now
                        sck      <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end
                end

                FETCH: begin
                    // sck stays low and mosi keeps the last bit while stalled.
                    if (pix_valid && pix_rdy) begin
                        state   <= LED;
                        pix_rdy <= 1'b0;
                        shreg   <= led_word;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end

                default: begin
                    // START, LED and END all shift 32 bits the same way.
                    if (!phase_end) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!sck) begin
                            sck <= 1'b1;
                        end else begin
                            sck <= 1'b0;
                            if (!last_bit) begin
                                bit_cnt <= bit_cnt + 5'd1;
                                shreg   <= shreg << 1;
                            end else begin
                                bit_cnt <= '0;
                                case (state)
                                    START: begin
                                        if (len_q != 5'd0) begin
                                            state   <= FETCH;
                                            pix_rdy <= 1'b1;
                                        end else begin
                                            state <= END;
                                            shreg <= '1;
                                        end
                                    end
                                    LED: begin
                                        word_cnt <= word_cnt_nxt;
                                        if (word_cnt_nxt < {1'b0, len_q}) begin
                                            state   <= FETCH;
                                            pix_rdy <= 1'b1;
                                        end else begin
                                            state <= END;
                                            shreg <= '1;
                                        end
                                    end
                                    default: begin
                                        // last end-frame bit finished its high phase
                                        state <= IDLE;
                                        done  <= 1'b1;
                                        grant <= '0;
                                        busy  <= 1'b0;
                                        shreg <= '0;
                                    end
                                endcase
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb_led_frame_scheduler
//
// Two instances: dut (DIV=1) carries the table of frames, the mid-frame reset
// and the pointer-reset sequence; dut2 (DIV=2) carries the pixel-stall frame.
// Expected serial bits are pushed to exp_q when a frame is requested and
// popped at every rising sck of the serializer being checked.

module tb_led_frame_scheduler;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;

    // dut (DIV=1)
    logic [N-1:0]    req;
    logic [N*5-1:0]  len;
    logic [4:0]      brightness;
    logic            pix_rdy;
    logic            pix_valid;
    logic [23:0]     pix_data;
    logic [N-1:0]    grant;
    logic            busy;
    logic            done;
    logic            sck;
    logic [N-1:0]    mosi;

    // dut2 (DIV=2)
    logic [N-1:0]    req2;
    logic [N*5-1:0]  len2;
    logic [4:0]      br2;
    logic            rdy2;
    logic            pv2;
    logic [23:0]     pd2;
    logic [N-1:0]    grant2;
    logic            busy2;
    logic            done2;
    logic            sck2;
    logic [N-1:0]    mosi2;

    always #5 clk = ~clk;

    led_frame_scheduler #(.NSTRAND(N), .DIV(1)) dut (
        .clk(clk), .reset(reset), .req(req), .len(len), .brightness(brightness),
        .pix_rdy(pix_rdy), .pix_valid(pix_valid), .pix_data(pix_data),
        .grant(grant), .busy(busy), .done(done), .sck(sck), .mosi(mosi)
    );

    led_frame_scheduler #(.NSTRAND(N), .DIV(2)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .len(len2), .brightness(br2),
        .pix_rdy(rdy2), .pix_valid(pv2), .pix_data(pd2),
        .grant(grant2), .busy(busy2), .done(done2), .sck(sck2), .mosi(mosi2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [0:0]  exp_q[$];
    logic [23:0] pix_q[$];
    int          bits_seen = 0;
    logic        prev_sck  = 1'b0;

    typedef struct {
        logic [3:0]  req;
        logic [19:0] len;
        logic [4:0]  br;
        logic [23:0] pix0;       // first pixel, 0 = random
        logic [3:0]  exp_grant;
        bit          hold;       // keep req asserted after grant
    } frame_t;

    frame_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] mk_len(input int l3, input int l2, input int l1, input int l0);
        return {5'(l3), 5'(l2), 5'(l1), 5'(l0)};
    endfunction

    // Expected frame: 32 zeros, one word per LED, 32 ones, MSB first.
    task automatic push_frame(input int nled, input logic [4:0] br, input logic [23:0] first_pix);
        logic [31:0] w;
        logic [23:0] p;
        pix_q.delete();
        repeat (32) exp_q.push_back(1'b0);
        for (int i = 0; i < nled; i++) begin
            p = (i == 0 && first_pix != 24'd0) ? first_pix : 24'($urandom);
            pix_q.push_back(p);
            w = {3'b111, br, p};
            for (int b = 31; b >= 0; b--) exp_q.push_back(w[b]);
        end
        repeat (32) exp_q.push_back(1'b1);
    endtask

    // Serial monitor for dut: one bit per rising sck, plus idle/ownership rules.
    always @(negedge clk) begin
        logic [0:0] e;
        if (reset) begin
            prev_sck = 1'b0;
        end else begin
            check("mosi_ungranted_zero", 32'(mosi & ~grant), 32'd0);
            if (grant == '0) check("sck_idle_low", 32'(sck), 32'd0);
            if (sck && !prev_sck) begin
                bits_seen++;
                check("bit_available", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("mosi_bit", 32'(|(mosi & grant)), 32'(e));
                end
            end
            prev_sck = sck;
        end
    end

    task automatic drive_pix(output bit took);
        if (pix_rdy && pix_q.size() > 0) begin
            pix_valid = 1'b1;
            pix_data  = pix_q[0];
            took      = 1'b1;
        end else begin
            // outside FETCH, random valid/data must be ignored
            pix_valid = pix_rdy ? 1'b0 : 1'($urandom_range(0, 1));
            pix_data  = 24'($urandom);
            took      = 1'b0;
        end
    endtask

    task automatic run_cycles(input int limit, output int cyc, output int acc, output bit got_done);
        bit took;
        cyc = 0;
        acc = 0;
        got_done = 1'b0;
        drive_pix(took);
        while (!got_done && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (took) begin
                void'(pix_q.pop_front());
                acc++;
            end
            if (done) got_done = 1'b1;
            else drive_pix(took);
        end
        pix_valid = 1'b0;
    endtask

    task automatic do_frame(input frame_t f, input string tag);
        int g, nled, cyc, acc, wait_c;
        bit got_done;
        g = 0;
        for (int i = 0; i < N; i++) if (f.exp_grant[i]) g = i;
        nled = int'(f.len[5*g +: 5]);
        push_frame(nled, f.br, f.pix0);
        bits_seen  = 0;
        req        = f.req;
        len        = f.len;
        brightness = f.br;
        wait_c = 0;
        do begin
            @(negedge clk);
            wait_c++;
        end while (grant == '0 && wait_c < 8);
        check({tag, "_grant"}, 32'(grant), 32'(f.exp_grant));
        check({tag, "_grant_latency"}, wait_c, 1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        if (!f.hold) req = '0;
        len        = 20'($urandom);
        brightness = 5'($urandom);
        run_cycles((nled + 2) * 64 + nled + 16, cyc, acc, got_done);
        check({tag, "_done_seen"}, 32'(got_done), 32'd1);
        check({tag, "_cycles"}, cyc, (nled + 2) * 64 + nled);
        check({tag, "_accepts"}, acc, nled);
        check({tag, "_bits"}, bits_seen, (nled + 2) * 32);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_grant_cleared"}, 32'(grant), 32'd0);
        check({tag, "_busy_cleared"}, 32'(busy), 32'd0);
        if (!got_done) begin
            exp_q.delete();
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end else if (!f.hold) begin
            repeat (4) begin
                @(negedge clk);
                check({tag, "_single_done"}, 32'(done), 32'd0);
                check({tag, "_idle_grant"}, 32'(grant), 32'd0);
            end
        end
    endtask

    task automatic stall_test();
        int cyc, acc, stall;
        bit got, took, in_stall;
        logic [N-1:0] hold_mosi;
        logic [0:0] e;
        logic p_sck;
        push_frame(2, 5'h0A, 24'd0);
        len2 = mk_len(0, 0, 0, 2);
        br2  = 5'h0A;
        req2 = 4'b0001;
        @(negedge clk);
        check("stall_grant", 32'(grant2), 32'h1);
        req2 = '0;
        len2 = 20'($urandom);
        cyc = 0; acc = 0; stall = 0; got = 1'b0; took = 1'b0; in_stall = 1'b0;
        p_sck = 1'b0; bits_seen = 0; hold_mosi = '0;
        while (!got && cyc < 700) begin
            @(negedge clk);
            cyc++;
            if (took) begin
                void'(pix_q.pop_front());
                acc++;
            end
            check("stall_mosi_ungranted", 32'(mosi2 & ~grant2), 32'd0);
            if (sck2 && !p_sck) begin
                bits_seen++;
                check("stall_bit_available", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("stall_mosi_bit", 32'(|(mosi2 & grant2)), 32'(e));
                end
            end
            p_sck = sck2;
            if (done2) got = 1'b1;
            if (!in_stall && stall == 0 && rdy2 && acc == 1) begin
                in_stall  = 1'b1;
                hold_mosi = mosi2;
            end
            if (in_stall) begin
                check("stall_pix_rdy", 32'(rdy2), 32'd1);
                check("stall_sck_low", 32'(sck2), 32'd0);
                check("stall_mosi_stable", 32'(mosi2), 32'(hold_mosi));
                pv2 = 1'b0;
                pd2 = 24'($urandom);
                took = 1'b0;
                stall++;
                if (stall == 50) in_stall = 1'b0;
            end else if (rdy2 && pix_q.size() > 0) begin
                pv2 = 1'b1;
                pd2 = pix_q[0];
                took = 1'b1;
            end else begin
                pv2 = 1'b0;
                took = 1'b0;
            end
        end
        pv2 = 1'b0;
        check("stall_done_seen", 32'(got), 32'd1);
        check("stall_cycles", cyc, 4 * 64 * 2 + 1 + 51);
        check("stall_accepts", acc, 2);
        check("stall_bits", bits_seen, 4 * 32);
        check("stall_queue_empty", exp_q.size(), 0);
        check("stall_grant_cleared", 32'(grant2), 32'd0);
    endtask

    initial begin
        int cyc, acc;
        bit got;
        frame_t f;

        reset = 1'b1;
        req = '0; len = '0; brightness = '0; pix_valid = 1'b0; pix_data = '0;
        req2 = '0; len2 = '0; br2 = '0; pv2 = 1'b0; pd2 = '0;

        tbl[0] = '{4'b0101, mk_len(0, 0, 0, 0),  5'h05, 24'd0,       4'b0001, 1'b1};
        tbl[1] = '{4'b0101, mk_len(0, 0, 0, 0),  5'h05, 24'd0,       4'b0100, 1'b1};
        tbl[2] = '{4'b0101, mk_len(0, 0, 0, 0),  5'h05, 24'd0,       4'b0001, 1'b0};
        tbl[3] = '{4'b0001, mk_len(0, 0, 0, 1),  5'h18, 24'h427AF4,  4'b0001, 1'b0};
        tbl[4] = '{4'b0010, mk_len(0, 0, 3, 0),  5'h0C, 24'd0,       4'b0010, 1'b0};
        tbl[5] = '{4'b1111, mk_len(2, 0, 1, 2),  5'h1F, 24'd0,       4'b0100, 1'b1};
        tbl[6] = '{4'b1011, mk_len(2, 0, 1, 2),  5'h11, 24'd0,       4'b1000, 1'b1};
        tbl[7] = '{4'b1011, mk_len(2, 0, 1, 2),  5'h07, 24'd0,       4'b0001, 1'b1};
        tbl[8] = '{4'b1010, mk_len(2, 0, 1, 2),  5'h13, 24'd0,       4'b0010, 1'b0};
        tbl[9] = '{4'b0001, mk_len(0, 0, 0, 31), 5'h00, 24'd0,       4'b0001, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_pix_rdy", 32'(pix_rdy), 32'd0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_grant", 32'(grant), 32'd0);
        end

        for (int i = 0; i < 10; i++) do_frame(tbl[i], $sformatf("tbl%0d", i));

        // Reset in the middle of an LED word of strand 1.
        push_frame(2, 5'h09, 24'd0);
        req = 4'b0010; len = mk_len(0, 0, 2, 0); brightness = 5'h09;
        @(negedge clk);
        check("mid_grant", 32'(grant), 32'b0010);
        req = '0;
        run_cycles(64 + 1 + 20, cyc, acc, got);
        check("mid_busy_before_reset", 32'(busy), 32'd1);
        check("mid_accepts_before_reset", acc, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_sck", 32'(sck), 32'd0);
        check("mid_rst_mosi", 32'(mosi), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pix_rdy", 32'(pix_rdy), 32'd0);
        exp_q.delete();
        req = 4'b1000; len = mk_len(1, 0, 0, 0); brightness = 5'h15;
        push_frame(1, 5'h15, 24'd0);
        @(negedge clk);
        reset = 1'b0;
        bits_seen = 0;
        @(negedge clk);
        check("post_rst_grant", 32'(grant), 32'b1000);
        req = '0;
        run_cycles(3 * 64 + 16, cyc, acc, got);
        check("post_rst_done", 32'(got), 32'd1);
        check("post_rst_cycles", cyc, 3 * 64 + 1);
        check("post_rst_bits", bits_seen, 3 * 32);
        check("post_rst_queue_empty", exp_q.size(), 0);

        // Round-robin pointer returns to strand 0 on reset.
        f = '{4'b0010, mk_len(0, 0, 0, 0), 5'h02, 24'd0, 4'b0010, 1'b0};
        do_frame(f, "rr_pre");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        f = '{4'b0110, mk_len(0, 0, 0, 0), 5'h03, 24'd0, 4'b0010, 1'b0};
        do_frame(f, "rr_post");

        stall_test();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
